seven_seg_scan: RTL

Time-multiplexed driver for an N-digit common-anode seven-segment display. Holds a tear-free shadow copy of all digit codes and decimal points, scans one digit at a time at a programmable refresh rate, and drives registered active-low anode enables plus active-high segment patterns. Sits between the display-value logic (score/counter/tree-walk result) and the board pins, replacing per-position manual selection.

---
 rtl/seven_seg_pkg.sv | 10 +
 rtl/seven_seg_decode.sv | 9 +
 rtl/seven_seg_scan.sv | 78 +++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: display code constants and the 16-entry segment pattern table (g..a, 1 = lit).
package seven_seg_pkg;
  localparam logic [3:0] CHAR_L     = 4'd10;
  localparam logic [3:0] CHAR_E     = 4'd11;
  localparam logic [3:0] CHAR_BLANK = 4'd15;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h38, 7'h79, 7'h00, 7'h00, 7'h00, 7'h00
  };
endpackage

// File: rtl/seven_seg_decode.sv
// seven_seg_decode: combinational 4-bit display code to g..a segment pattern.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] pat_o
);
  assign pat_o = SEG_LUT[code_i];
endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed N-digit common-anode driver with tear-free shadow registers.
// Define LEADING_ZERO_BLANK_EN to blank leading zero positions (position 0 always shown).
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter  int NUM_DIGITS  = 4,
  parameter  int REFRESH_DIV = 100000,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IW-1:0]           position
);
  logic [NUM_DIGITS-1:0][3:0] codes_q;
  logic [NUM_DIGITS-1:0]      dp_q, an_q, an_d;
  logic [PW-1:0]              pre_q, pre_d;
  logic [IW-1:0]              idx_q, idx_d, pos_q, pos_d;
  logic [7:0]                 seg_q, seg_d;
  logic [6:0]                 pat, lit;
  logic                       tc;

  seven_seg_decode u_dec (.code_i(codes_q[idx_q]), .pat_o(pat));

`ifdef LEADING_ZERO_BLANK_EN
  // zero_hi[i]: position i and every position above it hold code 0
  logic [NUM_DIGITS-1:0] zero_hi;
  always_comb begin
    zero_hi = '0;
    zero_hi[NUM_DIGITS-1] = codes_q[NUM_DIGITS-1] == 4'd0;
    for (int i = NUM_DIGITS - 2; i >= 0; i--) zero_hi[i] = (codes_q[i] == 4'd0) && zero_hi[i+1];
  end
  assign lit = (idx_q != '0 && zero_hi[idx_q]) ? 7'h00 : pat;
`else
  assign lit = pat;
`endif

  always_comb begin
    tc    = pre_q == PW'(REFRESH_DIV - 1);
    pre_d = !enable ? pre_q : tc ? '0 : pre_q + 1'b1;
    idx_d = !(enable && tc) ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    an_d  = enable ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    seg_d = enable ? {dp_q[idx_q], lit} : 8'h00;
    pos_d = enable ? idx_q : pos_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      codes_q <= {NUM_DIGITS{CHAR_BLANK}};
      dp_q    <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= 8'h00;
      pos_q   <= '0;
    end else begin
      if (load) begin
        codes_q <= digits_in;
        dp_q    <= dp_in;
      end
      pre_q <= pre_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      pos_q <= pos_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign position = pos_q;
endmodule
